// File: rtl/fetch_unit.sv
// fetch_unit: drives the PC register's next_pc/pc_enable, fetches the word at curr_pc
// over a req/ack instruction-memory port and holds it for decode under valid/ready.
// Taken branches/jumps from EX redirect the flow at any point. A redirect that lands
// while a fetch is still outstanding parks the old address in drain_addr so the
// request stays stable until memory answers, and that answer is thrown away.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] curr_pc,
    output logic [31:0] next_pc,
    output logic        pc_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;

    logic [31:0] redir_tgt;
    logic [31:0] seq_pc;

    // Targets are word-aligned; sequential advance wraps naturally at 2^32.
    assign redir_tgt = {redirect_pc[31:2], 2'b00};
    assign seq_pc    = curr_pc + 32'd4;

    // Next-state, register updates and all outputs decoded from state and inputs.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        drain_addr_d = drain_addr_q;
        pc_enable    = 1'b0;
        next_pc      = seq_pc;
        imem_req     = 1'b0;
        imem_addr    = curr_pc;
        instr_valid  = 1'b0;

        case (state_q)
            BOOT: begin
                // Load the reset vector; EX cannot have anything meaningful yet.
                pc_enable = 1'b1;
                next_pc   = RESET_PC;
                state_d   = REQ;
            end

            REQ: begin
                imem_req  = 1'b1;
                imem_addr = curr_pc;
                if (imem_ack && !redirect_valid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = curr_pc;
                    pc_enable  = 1'b1;
                    state_d    = VALID;
                end else if (imem_ack) begin
                    // Word arrived on the wrong path: drop it and refetch at target.
                    pc_enable = 1'b1;
                    next_pc   = redir_tgt;
                end else if (redirect_valid) begin
                    // Request is still open; keep presenting the old address.
                    drain_addr_d = curr_pc;
                    pc_enable    = 1'b1;
                    next_pc      = redir_tgt;
                    state_d      = DRAIN;
                end
            end

            VALID: begin
                instr_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_enable = 1'b1;
                    next_pc   = redir_tgt;
                    state_d   = REQ;
                end else if (id_ready) begin
                    state_d = REQ;
                end
            end

            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                // A later redirect only moves the PC; the stale fetch still completes.
                if (redirect_valid) begin
                    pc_enable = 1'b1;
                    next_pc   = redir_tgt;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    // State and holding registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            instr_q      <= 32'd0;
            instr_pc_q   <= 32'd0;
            drain_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign instr    = instr_q;
    assign instr_pc = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: models the PC register and a variable-latency instruction memory,
// predicts the program-order stream decode must see plus per-cycle handshake
// expectations, and pins that prediction with hand-timed directed scenarios.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] curr_pc = 32'd0;
    logic [31:0] next_pc;
    logic        pc_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .curr_pc(curr_pc), .next_pc(next_pc),
        .pc_enable(pc_enable), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Memory contents: any fixed function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Run configuration
    int          cfg_lat, cfg_rc, cfg_rlo, cfg_rhi, cfg_rst;
    bit          cfg_rand;
    logic [31:0] cfg_rt;

    // Reference model: external pc register, imem, expected delivery stream
    logic [31:0] pcreg = 32'd0;
    bit          im_busy = 0;
    int          im_cnt = 0;
    logic [31:0] im_addr = 32'd0;
    bit          m_init = 0, m_boot = 0, m_hold = 0, m_stale = 0;
    logic [31:0] m_pc = 32'd0;

    // Per-run trace and delivered-instruction log
    logic [31:0] tr_np [16];
    logic [31:0] tr_addr [16];
    logic [31:0] tr_ipc [16];
    bit          tr_pe [16];
    bit          tr_req [16];
    bit          tr_iv [16];
    logic [31:0] dq_pc [$];
    int          dq_cyc [$];

    task automatic setcfg(input int lat, input int rc, input logic [31:0] rt,
                          input int rlo, input int rhi, input int rst, input bit rnd);
        cfg_lat = lat; cfg_rc = rc; cfg_rt = rt; cfg_rlo = rlo; cfg_rhi = rhi;
        cfg_rst = rst; cfg_rand = rnd;
    endtask

    task automatic run(input int n);
        bit          act, rs, rv, rdy, ack, pe, req, iv, ivx, nh;
        logic [31:0] tgt, np;
        dq_pc.delete();
        dq_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            tr_np[i] = '0; tr_addr[i] = '0; tr_ipc[i] = '0;
            tr_pe[i] = 0; tr_req[i] = 0; tr_iv[i] = 0;
        end
        for (int c = -2; c < n; c++) begin
            // drive inputs for this cycle
            rs = (c >= 0) && (c != cfg_rst);
            if (cfg_rand && c > 0 && $urandom_range(0, 299) == 0) rs = 0;
            rst_n = rs;
            id_ready = cfg_rand ? ($urandom_range(0, 9) < 7) : !(c >= cfg_rlo && c <= cfg_rhi);
            if (cfg_rand) begin
                redirect_valid = ($urandom_range(0, 7) == 0);
                redirect_pc = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                           : (32'h3000 | ($urandom & 32'hFF));
            end else begin
                redirect_valid = (c == cfg_rc);
                redirect_pc = (c == cfg_rc) ? cfg_rt : $urandom;
            end
            curr_pc = pcreg;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            act = rs && m_init;
            #1;
            // memory answers after its chosen latency, address must not move meanwhile
            if (imem_req) begin
                if (!im_busy) begin
                    im_busy = 1;
                    im_cnt = (cfg_lat < 0) ? int'($urandom_range(0, 4)) : cfg_lat;
                    im_addr = imem_addr;
                end else if (act) begin
                    chk("imem_addr_hold", imem_addr, im_addr);
                end
                if (im_cnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = memfn(imem_addr);
                end
            end
            #1;
            rv = redirect_valid; rdy = id_ready; ack = imem_ack; tgt = redirect_pc & 32'hFFFF_FFFC;
            pe = pc_enable; np = next_pc; req = imem_req; iv = instr_valid;
            ivx = m_hold && !rv;
            if (act) begin
                if (m_boot) begin
                    chk("boot_pc_enable", pe, 1);
                    chk("boot_next_pc", np, RPC);
                    chk("boot_imem_req", req, 0);
                    chk("boot_instr_valid", iv, 0);
                end else begin
                    chk("instr_valid", iv, ivx);
                    chk("imem_req", req, !m_hold);
                    if (!m_hold && !m_stale) chk("imem_addr", imem_addr, m_pc);
                    chk("pc_enable", pe, rv || (!m_hold && ack && !m_stale));
                    if (pe) chk("next_pc", np, rv ? tgt : curr_pc + 32'd4);
                    if (ivx) begin
                        chk("instr_pc", instr_pc, m_pc);
                        chk("instr", instr, memfn(m_pc));
                    end
                    if (iv && rdy) begin
                        dq_pc.push_back(instr_pc);
                        dq_cyc.push_back(c);
                    end
                end
            end
            if (c >= 0 && c < 16) begin
                tr_np[c] = np; tr_addr[c] = imem_addr; tr_ipc[c] = instr_pc;
                tr_pe[c] = pe; tr_req[c] = req; tr_iv[c] = iv;
            end
            @(posedge clk);
            #1;
            if (!rs) begin
                m_init = 1; m_boot = 1; m_hold = 0; m_stale = 0;
                im_busy = 0; pcreg = 32'd0;
            end else begin
                if (pe) pcreg = np;
                if (!req || ack) im_busy = 0;
                else im_cnt--;
                if (m_boot) begin
                    m_boot = 0; m_hold = 0; m_stale = 0; m_pc = RPC;
                end else if (m_init) begin
                    if (rv) m_pc = tgt;
                    else if (ivx && rdy) m_pc = m_pc + 32'd4;
                    nh = m_hold ? !(rv || rdy) : (ack && !m_stale && !rv);
                    if (ack) m_stale = 0;
                    else if (rv && !m_hold) m_stale = 1;
                    m_hold = nh;
                end
            end
        end
    endtask

    initial begin
        // 1: boot, registered imem, decode always ready
        setcfg(1, -1, 0, -1, -1, -1, 0);
        run(10);
        chk("r1_boot_pe", tr_pe[0], 1);
        chk("r1_boot_np", tr_np[0], 32'h3000);
        chk("r1_c1_req", tr_req[1], 1);
        chk("r1_c1_addr", tr_addr[1], 32'h3000);
        chk("r1_c1_pe", tr_pe[1], 0);
        chk("r1_count", dq_pc.size(), 3);
        chk("r1_pc0", dq_pc[0], 32'h3000); chk("r1_cyc0", dq_cyc[0], 3);
        chk("r1_pc1", dq_pc[1], 32'h3004); chk("r1_cyc1", dq_cyc[1], 6);
        chk("r1_pc2", dq_pc[2], 32'h3008); chk("r1_cyc2", dq_cyc[2], 9);

        // 2: decode stalls cycles 3..7
        setcfg(1, -1, 0, 3, 7, -1, 0);
        run(12);
        chk("r2_stall_req", tr_req[5], 0);
        chk("r2_stall_pe", tr_pe[5], 0);
        chk("r2_stall_iv", tr_iv[7], 1);
        chk("r2_stall_ipc", tr_ipc[7], 32'h3000);
        chk("r2_cyc0", dq_cyc[0], 8);
        chk("r2_pc1", dq_pc[1], 32'h3004); chk("r2_cyc1", dq_cyc[1], 11);

        // 3: four wait states
        setcfg(4, -1, 0, -1, -1, -1, 0);
        run(8);
        chk("r3_wait_pe", tr_pe[4], 0);
        chk("r3_wait_req", tr_req[4], 1);
        chk("r3_wait_addr", tr_addr[4], 32'h3000);
        chk("r3_ack_pe", tr_pe[5], 1);
        chk("r3_ack_np", tr_np[5], 32'h3004);
        chk("r3_pc0", dq_pc[0], 32'h3000); chk("r3_cyc0", dq_cyc[0], 6);

        // 4: redirect while 3004 outstanding
        setcfg(1, 4, 32'h4001, -1, -1, -1, 0);
        run(9);
        chk("r4_redir_pe", tr_pe[4], 1);
        chk("r4_redir_np", tr_np[4], 32'h4000);
        chk("r4_drain_addr", tr_addr[5], 32'h3004);
        chk("r4_drain_pe", tr_pe[5], 0);
        chk("r4_refetch_addr", tr_addr[6], 32'h4000);
        chk("r4_count", dq_pc.size(), 2);
        chk("r4_pc1", dq_pc[1], 32'h4000); chk("r4_cyc1", dq_cyc[1], 8);

        // 5a: redirect while VALID and decode ready
        setcfg(1, 3, 32'h5000, -1, -1, -1, 0);
        run(7);
        chk("r5_iv_squash", tr_iv[3], 0);
        chk("r5_np", tr_np[3], 32'h5000);
        chk("r5_count", dq_pc.size(), 1);
        chk("r5_pc0", dq_pc[0], 32'h5000); chk("r5_cyc0", dq_cyc[0], 6);

        // 5b: redirect in the ack cycle
        setcfg(1, 2, 32'h6000, -1, -1, -1, 0);
        run(6);
        chk("r5b_np", tr_np[2], 32'h6000);
        chk("r5b_count", dq_pc.size(), 1);
        chk("r5b_pc0", dq_pc[0], 32'h6000); chk("r5b_cyc0", dq_cyc[0], 5);

        // 6a: wrap at top of address space
        setcfg(1, 3, 32'hFFFF_FFFC, -1, -1, -1, 0);
        run(10);
        chk("r6_wrap_np", tr_np[5], 32'h0);
        chk("r6_pc0", dq_pc[0], 32'hFFFF_FFFC); chk("r6_cyc0", dq_cyc[0], 6);
        chk("r6_pc1", dq_pc[1], 32'h0); chk("r6_cyc1", dq_cyc[1], 9);

        // 6b: reset during DRAIN
        setcfg(3, 7, 32'h4001, -1, -1, 8, 0);
        run(15);
        chk("r6b_redir_np", tr_np[7], 32'h4000);
        chk("r6b_drain_req", tr_req[8], 1);
        chk("r6b_drain_addr", tr_addr[8], 32'h3004);
        chk("r6b_boot_pe", tr_pe[9], 1);
        chk("r6b_boot_np", tr_np[9], 32'h3000);
        chk("r6b_boot_req", tr_req[9], 0);
        chk("r6b_boot_iv", tr_iv[9], 0);
        chk("r6b_count", dq_pc.size(), 2);
        chk("r6b_pc1", dq_pc[1], 32'h3000); chk("r6b_cyc1", dq_cyc[1], 14);

        // random traffic: latencies 0..4, stalls, redirects, occasional reset
        setcfg(-1, -1, 0, -1, -1, -1, 1);
        run(4000);
        chk("rand_progress", dq_pc.size() >= 150, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
